jpg_ioctl_streamer: RTL and testbench
=====================================

JPG_IOCTL_STREAMER -- requirements
Module: jpg_ioctl_streamer

Interface
REQ-001 SHALL provide parameter IOCTL_INDEX, default 8'd1: the ioctl_index value whose downloads are streamed; downloads with any other index are ignored.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4: beat FIFO depth, power of two, minimum 4.
REQ-003 SHALL provide ports, clock and reset first:
- clk_i  in  1  system clock (clk_sys)
- rst_i  in  1  reset, asynchronous, active-high
- ioctl_download_i  in  1  hps_io download active
- ioctl_index_i  in  8  download index
- ioctl_wr_i  in  1  single-cycle word strobe
- ioctl_addr_i  in  25  byte address of the word
- ioctl_data_i  in  16  word; [7:0] is the byte at the even address
- ioctl_wait_o  out  1  back-pressure to hps_io
- inport_valid_o  out  1  beat valid to jpeg_core
- inport_data_o  out  32  beat; [7:0] is the earliest byte
- inport_strb_o  out  4  byte enables
- inport_last_o  out  1  final beat of the file
- inport_accept_i  in  1  jpeg_core accepts the beat
- busy_o  out  1  high when state is not IDLE or the FIFO is not empty
- byte_count_o  out  25  bytes received in the current or most recent download

Function
REQ-004 SHALL implement the states IDLE, LOAD and FLUSH.
REQ-005 IDLE->LOAD SHALL occur when ioctl_download_i=1 and ioctl_index_i=IOCTL_INDEX; on entry, byte_count_o, the half-word phase and the pending-beat flag SHALL clear.
REQ-006 In LOAD, each ioctl_wr_i SHALL store ioctl_data_i into the low half of the assembly register when ioctl_addr_i[1]=0, and into the high half when ioctl_addr_i[1]=1.
REQ-007 Each ioctl_wr_i in LOAD SHALL add 2 to byte_count_o (25-bit, wraps modulo 2^25).
REQ-008 A completed 32-bit beat SHALL move into a one-beat pending register; any previously pending beat SHALL be pushed to the FIFO with last=0 in the same cycle.
REQ-009 LOAD->FLUSH SHALL occur when ioctl_download_i falls.
REQ-010 In FLUSH, when the FIFO is not full, the module SHALL push exactly one final beat with last=1, then go to IDLE:
- if a half word is held: the pending beat (if any) is pushed first with last=0, then the half word with strb 4'b0011 and last=1; this takes two cycles
- otherwise: the pending beat with strb 4'b1111 and last=1
- if no bytes were received: nothing is pushed
REQ-011 ioctl_wait_o SHALL be registered and SHALL be 1 whenever free FIFO slots < 2 or the state is FLUSH; otherwise 0.
REQ-012 Full beats SHALL carry strb 4'b1111.
REQ-013 Output beats SHALL follow valid/accept semantics: a beat transfers on a cycle with inport_valid_o=1 and inport_accept_i=1.
REQ-014 inport_valid_o SHALL equal FIFO not empty; data, strb and last SHALL be the FIFO head.
REQ-015 While inport_valid_o=1 and inport_accept_i=0, the data, strb and last outputs SHALL be held stable.
REQ-016 A push and a pop in the same cycle SHALL leave the FIFO count unchanged, including when the FIFO is full or empty.
REQ-017 A push into a full FIFO SHALL NOT occur; hold-off is guaranteed by REQ-011. A pop from an empty FIFO SHALL be impossible.
REQ-018 ioctl_wr_i outside LOAD, or with a non-matching index, SHALL be ignored.
REQ-019 A new download MAY start while the FIFO still drains; beat order across files SHALL be preserved.

Reset
REQ-020 On rst_i=1, asynchronously:
- state SHALL become IDLE and the FIFO SHALL empty
- inport_valid_o, inport_last_o, ioctl_wait_o and busy_o SHALL be 0
- inport_data_o and inport_strb_o SHALL be 0
- byte_count_o SHALL be 0
REQ-021 A reset during a download SHALL discard all partial beats; subsequent writes of that download SHALL be ignored until ioctl_download_i falls and rises again.

Structure
REQ-022 Package jpg_stream_pkg SHALL hold:
- the beat struct (data[31:0], strb[3:0], last)
- the state enum
- constants STRB_FULL and STRB_HALF
REQ-023 The FIFO SHALL be a single sub-module, jpg_beat_fifo, parameterized by depth and beat type; all other logic lives in jpg_ioctl_streamer.

Verification
REQ-024 8 bytes 00..07 written, accept tied 1 -> beats 0x03020100 (strb F, last 0) then 0x07060504 (strb F, last 1); byte_count_o=8.
REQ-025 6 bytes AA..AF written -> beats 0xADACABAA (strb F, last 0) then 0x0000AFAE (strb 3, last 1).
REQ-026 accept held 0 during a 64-byte download -> ioctl_wait_o rises when 3 beats are queued and no beat is lost. After accept=1: 16 beats in order, only the 16th with last=1.
REQ-027 Download with ioctl_index_i=0 -> no beats and byte_count_o=0. Zero-length download with index 1 -> no beats and busy_o returns to 0.
REQ-028 rst_i pulsed after 5 of 10 words -> FIFO empty and inport_valid_o=0 within the reset cycle. Next full 4-byte download -> a single beat with last=1.
REQ-029 Random accept pattern with simultaneous push/pop at full and empty -> output byte stream equals input bytes and ioctl_wait_o is never low while free slots < 2.

Source files
------------

// File: rtl/jpg_stream_pkg.sv
// Shared types and constants for the ioctl-to-jpeg beat streamer.
package jpg_stream_pkg;

  // One output beat: four bytes, byte enables and end-of-file marker.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  // Download sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] STRB_FULL = 4'b1111;
  localparam logic [3:0] STRB_HALF = 4'b0011;

  // Build a beat from its fields.
  function automatic beat_t make_beat(input logic [31:0] data,
                                      input logic [3:0]  strb,
                                      input logic        last);
    beat_t b;
    b.data = data;
    b.strb = strb;
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/jpg_beat_fifo.sv
// Small synchronous FIFO of beats. A push while full is only taken when a
// pop happens in the same cycle; a pop while empty is ignored.
module jpg_beat_fifo
  import jpg_stream_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = jpg_stream_pkg::beat_t,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  item_t       push_data_i,
  input  logic        pop_i,
  output item_t       head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  item_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Qualify requests and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/jpg_ioctl_streamer.sv
// Converts hps_io 16-bit ioctl download words into 32-bit valid/accept
// beats for jpeg_core. The most recent complete beat is held back in a
// pending register so that the final beat of a file can be tagged last.
module jpg_ioctl_streamer
  import jpg_stream_pkg::*;
#(
  parameter logic [7:0] IOCTL_INDEX = 8'd1,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ioctl_download_i,
  input  logic [7:0]  ioctl_index_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [15:0] ioctl_data_i,
  output logic        ioctl_wait_o,
  output logic        inport_valid_o,
  output logic [31:0] inport_data_o,
  output logic [3:0]  inport_strb_o,
  output logic        inport_last_o,
  input  logic        inport_accept_i,
  output logic        busy_o,
  output logic [24:0] byte_count_o
);

  localparam int          CW        = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0] CNT_ONE   = (CW+1)'(1);
  localparam logic [CW:0] CNT_TWO   = (CW+1)'(2);

  state_e      state_q, state_d;
  logic [31:0] asm_q, asm_d;
  logic        half_q, half_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [24:0] byte_cnt_q, byte_cnt_d;
  logic        wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        block_q, block_d;

  logic        index_match_s;
  logic        wr_ok_s;
  logic        push_s;
  logic        push_ok_s;
  logic        pop_s;
  beat_t       push_beat_s;
  beat_t       head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [CW:0] fifo_count_s;
  logic [CW:0] count_nxt_s;
  logic [CW:0] free_nxt_s;
  logic        unused_addr_s;

  assign index_match_s = (ioctl_index_i == IOCTL_INDEX);
  assign wr_ok_s       = ioctl_wr_i && index_match_s && (state_q == ST_LOAD);
  assign pop_s         = !fifo_empty_s && inport_accept_i;
  assign push_ok_s     = push_s && (!fifo_full_s || pop_s);
  assign unused_addr_s = ^{ioctl_addr_i[24:2], ioctl_addr_i[0]};

  // Sequencing FSM: word assembly, pending beat hand-off and final flush.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    half_d      = half_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    byte_cnt_d  = byte_cnt_q;
    push_s      = 1'b0;
    push_beat_s = '0;
    // After a reset mid-download, wait for the download strobe to drop.
    if (!ioctl_download_i) begin
      block_d = 1'b0;
    end else begin
      block_d = block_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download_i && index_match_s && !block_q) begin
          state_d    = ST_LOAD;
          byte_cnt_d = 25'd0;
          half_d     = 1'b0;
          pend_vld_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_ok_s) begin
          byte_cnt_d = byte_cnt_q + 25'd2;
          if (!ioctl_addr_i[1]) begin
            asm_d[15:0] = ioctl_data_i;
            half_d      = 1'b1;
          end else begin
            asm_d[31:16] = ioctl_data_i;
            half_d       = 1'b0;
            pend_d       = {ioctl_data_i, asm_q[15:0]};
            pend_vld_d   = 1'b1;
            if (pend_vld_q) begin
              push_s      = 1'b1;
              push_beat_s = make_beat(pend_q, STRB_FULL, 1'b0);
            end else begin
              push_s = 1'b0;
            end
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
        if (!ioctl_download_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (!fifo_full_s) begin
          if (half_q) begin
            if (pend_vld_q) begin
              push_s      = 1'b1;
              push_beat_s = make_beat(pend_q, STRB_FULL, 1'b0);
              pend_vld_d  = 1'b0;
              state_d     = ST_FLUSH;
            end else begin
              push_s      = 1'b1;
              push_beat_s = make_beat({16'h0000, asm_q[15:0]}, STRB_HALF, 1'b1);
              half_d      = 1'b0;
              state_d     = ST_IDLE;
            end
          end else if (pend_vld_q) begin
            push_s      = 1'b1;
            push_beat_s = make_beat(pend_q, STRB_FULL, 1'b1);
            pend_vld_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this cycle, used to register wait and busy.
  always_comb begin
    count_nxt_s = fifo_count_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = fifo_count_s + CNT_ONE;
      2'b01:   count_nxt_s = fifo_count_s - CNT_ONE;
      default: count_nxt_s = fifo_count_s;
    endcase
    free_nxt_s = DEPTH_CNT - count_nxt_s;
    wait_d     = (free_nxt_s < CNT_TWO) || (state_d == ST_FLUSH);
    busy_d     = (state_d != ST_IDLE) || (count_nxt_s != '0);
  end

  // State, assembly and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      asm_q      <= 32'd0;
      half_q     <= 1'b0;
      pend_q     <= 32'd0;
      pend_vld_q <= 1'b0;
      byte_cnt_q <= 25'd0;
      wait_q     <= 1'b0;
      busy_q     <= 1'b0;
      block_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      byte_cnt_q <= byte_cnt_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      block_q    <= block_d;
    end
  end

  jpg_beat_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (beat_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (push_beat_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  assign ioctl_wait_o   = wait_q;
  assign busy_o         = busy_q;
  assign byte_count_o   = byte_cnt_q;
  assign inport_valid_o = !fifo_empty_s;
  assign inport_data_o  = head_s.data;
  assign inport_strb_o  = head_s.strb;
  assign inport_last_o  = head_s.last;

endmodule

// File: tb/tb_jpg_ioctl_streamer.sv
// Self-checking bench: a file-level beat model (bytes -> 4-byte chunks)
// is compared against every transferred output beat.
module tb_jpg_ioctl_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [24:0] addr;
  logic [15:0] wdata;
  logic        wait_o;
  logic        valid;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        last;
  logic        accept;
  logic        busy;
  logic [24:0] bc;

  always #5 clk = ~clk;

  jpg_ioctl_streamer #(.IOCTL_INDEX(8'd1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .ioctl_download_i(dl), .ioctl_index_i(idx),
    .ioctl_wr_i(wr), .ioctl_addr_i(addr), .ioctl_data_i(wdata),
    .ioctl_wait_o(wait_o), .inport_valid_o(valid), .inport_data_o(data),
    .inport_strb_o(strb), .inport_last_o(last), .inport_accept_i(accept),
    .busy_o(busy), .byte_count_o(bc)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  logic [7:0]  buf_b [0:255];
  int acc_mode = 1;
  int gap_max = 0;
  int wr_done = 0;
  int first_wait_wr = -1;
  logic wait_arm = 1'b0;
  logic wait_seen = 1'b0;
  logic [24:0] last_bc = 25'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected beats for a file of nbytes bytes taken from buf_b.
  function automatic void model_file(input int nbytes);
    for (int b = 0; b < nbytes; b += 4) begin
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
      if (nbytes - b >= 4) begin
        d = {buf_b[b+3], buf_b[b+2], buf_b[b+1], buf_b[b]};
        s = 4'hF;
      end else begin
        d = {16'h0000, buf_b[b+1], buf_b[b]};
        s = 4'h3;
      end
      l = (b + 4 >= nbytes);
      exp_q.push_back({d, s, l});
    end
  endfunction

  // Accept pattern driver.
  always begin
    case (acc_mode)
      0:       accept = 1'b0;
      1:       accept = 1'b1;
      default: accept = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  end

  // Output monitor: compare transfers, check hold-stable while stalled.
  logic        stall = 1'b0;
  logic [36:0] stall_v;
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", {63'd0, valid}, 64'd1);
        check("hold_beat", {27'd0, data, strb, last}, {27'd0, stall_v});
      end
      if (valid && accept) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected none", {data, strb, last});
        end else begin
          check("beat", {27'd0, data, strb, last}, {27'd0, exp_q.pop_front()});
        end
        obs_q.push_back({data, strb, last});
      end
      stall   = valid && !accept;
      stall_v = {data, strb, last};
      if (wait_arm && !wait_seen && wait_o) begin
        wait_seen     = 1'b1;
        first_wait_wr = wr_done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
    int t = 0;
    int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) tick();
    while (wait_o && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) begin
      check("wait_timeout", 64'd1, 64'd0);
    end
    wr = 1'b1;
    addr = a;
    wdata = d;
    wr_done++;
    tick();
    wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] i);
    idx = i;
    dl = 1'b1;
    repeat (2) tick();
  endtask

  task automatic end_dl();
    int t = 0;
    dl = 1'b0;
    wr = 1'b0;
    repeat (2) tick();
    while (wait_o && t < 2000) begin
      tick();
      t++;
    end
  endtask

  task automatic run_file(input logic [7:0] i, input int nw);
    if (i == 8'd1) begin
      model_file(2 * nw);
      last_bc = 25'(2 * nw);
    end
    start_dl(i);
    for (int k = 0; k < nw; k++) begin
      wr_word(25'(2 * k), {buf_b[2*k+1], buf_b[2*k]});
    end
    end_dl();
    check("byte_count", {39'd0, bc}, {39'd0, last_bc});
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      tick();
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic fill_seq(input logic [7:0] s);
    for (int b = 0; b < 256; b++) buf_b[b] = s + 8'(b);
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 256; b++) buf_b[b] = 8'($urandom);
  endtask

  initial begin
    int base;
    int nlast;
    rst = 1'b1; dl = 1'b0; idx = 8'd0; wr = 1'b0; addr = 25'd0; wdata = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_last", {63'd0, last}, 64'd0);
    check("rst_data", {32'd0, data}, 64'd0);
    check("rst_strb", {60'd0, strb}, 64'd0);
    check("rst_wait", {63'd0, wait_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bc", {39'd0, bc}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Non-matching index: ignored entirely.
    fill_seq(8'h10);
    run_file(8'd0, 4);
    repeat (10) tick();
    check("idx0_beats", 64'(obs_q.size()), 64'd0);
    check("idx0_busy", {63'd0, busy}, 64'd0);

    // Zero-length download.
    run_file(8'd1, 0);
    drain();
    check("zero_beats", 64'(obs_q.size()), 64'd0);

    // 8 bytes 00..07.
    fill_seq(8'h00);
    base = obs_q.size();
    run_file(8'd1, 4);
    drain();
    check("r24_count", 64'(obs_q.size() - base), 64'd2);
    check("r24_b0", {27'd0, obs_q[base]}, {27'd0, 32'h03020100, 4'hF, 1'b0});
    check("r24_b1", {27'd0, obs_q[base+1]}, {27'd0, 32'h07060504, 4'hF, 1'b1});
    check("r24_bc", {39'd0, bc}, 64'd8);

    // 6 bytes AA..AF.
    fill_seq(8'hAA);
    base = obs_q.size();
    run_file(8'd1, 3);
    drain();
    check("r25_count", 64'(obs_q.size() - base), 64'd2);
    check("r25_b0", {27'd0, obs_q[base]}, {27'd0, 32'hADACABAA, 4'hF, 1'b0});
    check("r25_b1", {27'd0, obs_q[base+1]}, {27'd0, 32'h0000AFAE, 4'h3, 1'b1});

    // 64 bytes with accept held low, then released.
    fill_rand();
    base = obs_q.size();
    acc_mode = 0;
    wr_done = 0;
    wait_seen = 1'b0;
    wait_arm = 1'b1;
    fork
      run_file(8'd1, 32);
      begin
        repeat (60) tick();
        check("r26_wait_held", {63'd0, wait_o}, 64'd1);
        acc_mode = 1;
      end
    join
    drain();
    wait_arm = 1'b0;
    check("r26_wait_seen", {63'd0, wait_seen}, 64'd1);
    check("r26_wait_at_write", 64'(first_wait_wr), 64'd8);
    check("r26_count", 64'(obs_q.size() - base), 64'd16);
    nlast = 0;
    for (int k = base; k < obs_q.size(); k++) nlast += int'(obs_q[k][0]);
    check("r26_nlast", 64'(nlast), 64'd1);
    check("r26_final_last", {63'd0, obs_q[obs_q.size()-1][0]}, 64'd1);

    // Reset in the middle of a 10-word download.
    fill_rand();
    base = obs_q.size();
    acc_mode = 0;
    start_dl(8'd1);
    for (int k = 0; k < 5; k++) wr_word(25'(2 * k), {buf_b[2*k+1], buf_b[2*k]});
    rst = 1'b1;
    #1;
    check("r28_valid", {63'd0, valid}, 64'd0);
    check("r28_busy", {63'd0, busy}, 64'd0);
    check("r28_wait", {63'd0, wait_o}, 64'd0);
    tick();
    rst = 1'b0;
    last_bc = 25'd0;
    acc_mode = 1;
    for (int k = 5; k < 10; k++) wr_word(25'(2 * k), {buf_b[2*k+1], buf_b[2*k]});
    repeat (5) tick();
    check("r28_ignored_bc", {39'd0, bc}, 64'd0);
    check("r28_ignored_beats", 64'(obs_q.size() - base), 64'd0);
    end_dl();
    fill_seq(8'h40);
    run_file(8'd1, 2);
    drain();
    check("r28_count", 64'(obs_q.size() - base), 64'd1);
    check("r28_beat", {27'd0, obs_q[obs_q.size()-1]}, {27'd0, 32'h43424140, 4'hF, 1'b1});

    // Randomized files, accept pattern and write gaps.
    acc_mode = 2;
    for (int f = 0; f < 14; f++) begin
      fill_rand();
      gap_max = int'($urandom_range(0, 2));
      run_file(($urandom_range(0, 3) == 0) ? 8'd0 : 8'd1, int'($urandom_range(0, 24)));
    end
    drain();
    acc_mode = 1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
